seq_multiplier: RTL
===================

# seq_multiplier

Iterative radix-2 shift-add multiplier: the parametrised successor to the team's combinational multiplier, trading area for latency. It accepts an N×N operand pair through a valid/ready handshake, computes the 2N-bit product over N clock cycles, and holds the result under a valid/ready output handshake. It targets datapaths where a full array multiplier is too large and back-pressure from downstream is required.

## Interface
- `N`, default 8: operand width in bits; legal range N ≥ 2.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  operand pair on `a`/`b`/`signed_mode` is valid.
- `in_ready`  output  1  block can accept operands; high only in IDLE.
- `a`  input  N  multiplicand.
- `b`  input  N  multiplier.
- `signed_mode`  input  1  1 means two's-complement operands and result; 0 means unsigned. Sampled at acceptance.
- `out_valid`  output  1  `result` holds a completed product.
- `out_ready`  input  1  downstream consumes `result`.
- `result`  output  2N  product.
- `busy`  output  1  high in CALC or DONE.

## Operation
- FSM states: IDLE, CALC, DONE. Reset state is IDLE.
- IDLE: `in_ready`=1. When `in_valid`&&`in_ready` is true at an edge:
  - latch operand magnitudes into internal registers;
  - latch the product sign (a[N-1]^b[N-1] when signed, else 0);
  - clear the accumulator and the bit counter;
  - go to CALC.
- CALC: on each edge, if multiplier LSB=1, add the multiplicand (zero-extended, 2N bits) to the accumulator. Then shift the multiplicand left 1 and the multiplier right 1, and increment the counter (width $clog2(N)+1).
  - After the N-th CALC edge, go to DONE and load `result` with the accumulator, negated if the product sign is 1.
- DONE: `out_valid`=1. On the edge where `out_ready`=1, return to IDLE. `out_valid` stays high with `result` stable until that edge.
- Arithmetic:
  - unsigned operands are taken as-is;
  - in signed mode, magnitude = two's-complement negate of a negative operand. The −2^(N−1) case yields magnitude 2^(N−1) as an unsigned N-bit value.
  - The result is always exact in 2N bits, with no overflow: signed −2^(N−1)×−2^(N−1) = 2^(2N−2).
- Inputs `a`, `b` and `signed_mode` are ignored outside the acceptance edge. Changing them during CALC has no effect.
- `in_valid` asserted outside IDLE is ignored and not queued. Upstream holds it until it sees `in_ready`.
- `result` holds its last value in IDLE and CALC, until the next DONE load.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `busy`=0, `result`=0. All internal registers are 0 and the state is IDLE.
- Latency: with acceptance at edge E, `out_valid` rises after edge E+N, so it is visible N cycles after acceptance.
- Minimum issue interval: N+2 cycles (accept, N CALC, one DONE cycle with `out_ready`=1). There is no same-cycle accept in DONE.
- `out_ready` held low keeps the block in DONE indefinitely, with `in_ready`=0.
- Reset asserted mid-CALC or mid-DONE aborts immediately (asynchronously) to IDLE with the reset values above. The in-flight result is lost.
- `in_ready` and `out_valid` are registered state decodes, with no combinational path from inputs.

## Configuration
- `SEQ_MULT_SIGNED_EN` defined: signed mode is supported as described; the magnitude/negate logic is compiled in.
- Undefined: the `signed_mode` port remains but is ignored. All operations are unsigned and the sign/negate logic is removed.

## Test plan
- Reset, then N=8, unsigned: a=255, b=255, `out_ready`=1 → `out_valid` rises 8 cycles after accept with `result`=0xFE01; `in_ready` returns high the next cycle.
- Signed (macro defined): a=0x80, b=0x80 → `result`=0x4000. Then a=0xFD (−3), b=0x07 → `result`=0xFFEB (−21).
- Back-pressure: a=12, b=10, `out_ready`=0 for 20 cycles → `out_valid` stays high with `result`=120, and `in_valid` with a new pair is not accepted. Raise `out_ready` → IDLE next edge.
- Operand change mid-CALC: accept a=3, b=5, then drive a=0xFF, b=0xFF during CALC → `result`=15.
- Reset mid-CALC: assert `rst_n`=0 at cycle 4 → outputs immediately take reset values; after release, a new op (a=2, b=9) gives 18.
- Random regression, 1000 pairs per mode, random `out_ready` stalls → `result` equals the reference a*b (signed/unsigned) on every `out_valid`&&`out_ready`. With the macro undefined, signed_mode=1 still gives unsigned products.

Source files
------------

// File: rtl/seq_multiplier.sv
// seq_multiplier: iterative radix-2 shift-add NxN multiplier with valid/ready handshakes; define SEQ_MULT_SIGNED_EN to honour signed_mode
module seq_multiplier #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  input  logic           signed_mode,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] result,
  output logic           busy
);
  localparam int CW = $clog2(N) + 1;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state_q, state_d;
  logic [2*N-1:0] mcand_q, mcand_d, acc_q, acc_d, result_q, result_d, acc_sum, prod;
  logic [N-1:0] mplier_q, mplier_d, mag_a, mag_b;
  logic [CW-1:0] cnt_q, cnt_d;
  logic sign_q, sign_d, sign_in;
`ifdef SEQ_MULT_SIGNED_EN
  // -2^(N-1) negates to itself, which read as unsigned is the correct magnitude
  assign mag_a = (signed_mode && a[N-1]) ? -a : a;
  assign mag_b = (signed_mode && b[N-1]) ? -b : b;
  assign sign_in = signed_mode && (a[N-1] ^ b[N-1]);
  assign prod = sign_q ? -acc_sum : acc_sum;
`else
  logic unused_sign;
  assign unused_sign = signed_mode ^ sign_q;
  assign mag_a = a;
  assign mag_b = b;
  assign sign_in = 1'b0;
  assign prod = acc_sum;
`endif
  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sign_d   = sign_q;
    result_d = result_q;
    if (state_q == IDLE && in_valid) begin
      state_d  = CALC;
      mcand_d  = {{N{1'b0}}, mag_a};
      mplier_d = mag_b;
      sign_d   = sign_in;
      acc_d    = '0;
      cnt_d    = '0;
    end else if (state_q == CALC) begin
      acc_d    = acc_sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      if (cnt_q == CW'(N - 1)) begin
        state_d  = DONE;
        result_d = prod;
      end
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      sign_q   <= sign_d;
      result_q <= result_d;
    end
  end
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign busy      = state_q != IDLE;
  assign result    = result_q;
endmodule
